// File: rtl/fifo32_pkg.sv
// rtl/fifo32_pkg.sv - shared constants and helpers for the 32-deep LUT RAM FIFO
package fifo32_pkg;

  localparam int DEPTH = 32;
  localparam int PTR_W = 5;
  localparam int CNT_W = 6;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Occupancy after one edge: a simultaneous read and write cancel out
  function automatic cnt_t next_count(input cnt_t cur, input logic wr_acc, input logic rd_acc);
    cnt_t res;
    case ({wr_acc, rd_acc})
      2'b10:   res = cur + cnt_t'(1);
      2'b01:   res = cur - cnt_t'(1);
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/RAM32X1D.sv
// rtl/RAM32X1D.sv - 32x1 dual-port distributed RAM primitive, synchronous write, async reads
module RAM32X1D (
  input  logic       WCLK,
  input  logic       WE,
  input  logic [4:0] A,
  input  logic [4:0] DPRA,
  input  logic       D,
  output logic       SPO,
  output logic       DPO
);

  logic mem [0:31];

  // Write port: one bit per edge at address A
  always_ff @(posedge WCLK) begin
    if (WE) begin
      mem[A] <= D;
    end
  end

  assign SPO = mem[A];
  assign DPO = mem[DPRA];

endmodule

// File: rtl/fifo32_ctrl.sv
// rtl/fifo32_ctrl.sv - pointers, occupancy counter and status flags for the 32-deep FIFO
module fifo32_ctrl
  import fifo32_pkg::*;
#(
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [PTR_W-1:0] wptr,
  output logic [PTR_W-1:0] rptr,
  output logic             wr_acc,
  output logic             rd_acc,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             ovf,
  output logic             unf,
  output logic             dvalid
);

  cnt_t cnt_nxt;

  // Registered full/empty gate acceptance, so a full FIFO never passes data through
  assign wr_acc = wr_en & ~full  & ~clr;
  assign rd_acc = rd_en & ~empty & ~clr;

  // Next occupancy; flush wins over any request
  always_comb begin
    cnt_nxt = '0;
    if (!clr) begin
      cnt_nxt = next_count(count, wr_acc, rd_acc);
    end
  end

  // Pointers and sticky error flags; pointers wrap naturally at 5 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ptr_t'(1);
      if (rd_acc) rptr <= rptr + ptr_t'(1);
      if (wr_en && full)  ovf <= 1'b1;
      if (rd_en && empty) unf <= 1'b1;
    end
  end

  // Counter and level flags all come from next-state count so they agree each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      dvalid       <= 1'b0;
    end else begin
      count        <= cnt_nxt;
      full         <= (cnt_nxt == cnt_t'(DEPTH));
      empty        <= (cnt_nxt == '0);
      almost_full  <= (cnt_nxt >= cnt_t'(AF_LEVEL));
      almost_empty <= (cnt_nxt <= cnt_t'(AE_LEVEL));
      dvalid       <= rd_acc;
    end
  end

endmodule

// File: rtl/lutram_fifo32.sv
// rtl/lutram_fifo32.sv - 32-entry synchronous FIFO on distributed RAM with registered output
module lutram_fifo32
  import fifo32_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             dvalid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] ram_dout;
  logic [WIDTH-1:0] spo_unused;

  fifo32_ctrl #(
    .AF_LEVEL (AF_LEVEL),
    .AE_LEVEL (AE_LEVEL)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .wptr         (wptr),
    .rptr         (rptr),
    .wr_acc       (wr_acc),
    .rd_acc       (rd_acc),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ovf          (ovf),
    .unf          (unf),
    .dvalid       (dvalid)
  );

  // One 32x1 RAM per data bit; the read port always follows rptr
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    RAM32X1D u_ram (
      .WCLK (clk),
      .WE   (wr_acc),
      .A    (wptr),
      .DPRA (rptr),
      .D    (din[i]),
      .SPO  (spo_unused[i]),
      .DPO  (ram_dout[i])
    );
  end

  // Output register captures the head entry only on an accepted read; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (rd_acc) begin
      dout <= ram_dout;
    end
  end

endmodule
